// File: rtl/wave_switch_ctrl_pkg.sv
// Shared types and constants for the waveform switch controller.
package wave_switch_ctrl_pkg;

  // Output fader states
  typedef enum logic [1:0] {
    MUTE     = 2'd0,
    FADE_IN  = 2'd1,
    PLAY     = 2'd2,
    FADE_OUT = 2'd3
  } wave_state_e;

  // One switch bit and one oscillator input per waveform
  localparam int NUM_WAVES     = 5;
  localparam int WAVE_SINE     = 0;
  localparam int WAVE_SQUARE   = 1;
  localparam int WAVE_TRIANGLE = 2;
  localparam int WAVE_SAWTOOTH = 3;
  localparam int WAVE_NOISE    = 4;

  // Audio sample rate the tick divider is sized for
  localparam int SAMPLING_FREQ = 48000;

  // Index of the set bit in a one-hot selection (0 when nothing is set)
  function automatic logic [2:0] onehot_index(input logic [NUM_WAVES-1:0] sel);
    onehot_index = '0;
    for (int i = 0; i < NUM_WAVES; i++) begin
      if (sel[i]) onehot_index = 3'(i);
    end
  endfunction

endpackage

// File: rtl/wave_switch_ctrl_debounce.sv
// Tick-enabled switch debouncer: a new switch pattern is accepted only after
// it has been seen unchanged on debounce_p consecutive sample ticks.
module switch_debounce #(
  parameter int debounce_p = 4,
  parameter int width_p    = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               tick_i,
  input  logic [width_p-1:0] sw_i,
  output logic [width_p-1:0] sel_o
);

  localparam int CNT_W = $clog2(debounce_p + 1);
  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(debounce_p);

  logic [width_p-1:0] candidate_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_next;

  // A differing sample starts a fresh run of one; equal samples extend the run up to the limit
  always_comb begin
    count_next = count_q;
    if (sw_i != candidate_q) begin
      count_next = CNT_W'(1);
    end else if (count_q != COUNT_MAX) begin
      count_next = count_q + 1'b1;
    end
  end

  // Track the candidate pattern and publish it once its run is long enough
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      candidate_q <= '0;
      count_q     <= '0;
      sel_o       <= '0;
    end else if (tick_i) begin
      candidate_q <= sw_i;
      count_q     <= count_next;
      if (count_next >= COUNT_MAX) sel_o <= sw_i;
    end
  end

endmodule

// File: rtl/wave_switch_ctrl.sv
// Waveform selector with click-free switching: the active oscillator is faded
// out to silence before the newly selected one is faded in, one gain step per
// sample tick. Scaled samples are offered downstream with a valid/ready pair.
module wave_switch_ctrl
  import wave_switch_ctrl_pkg::*;
#(
  parameter int width_p      = 24,
  parameter int clk_div_p    = 250,
  parameter int debounce_p   = 4,
  parameter int fade_steps_p = 64
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [NUM_WAVES-1:0]                   sw_i,
  input  logic signed [NUM_WAVES-1:0][width_p-1:0] wave_i,
  output logic [NUM_WAVES-1:0]                   osc_ready_o,
  output logic signed [width_p-1:0]              data_o,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  output logic                                   overrun_o
);

  localparam int SHIFT  = $clog2(fade_steps_p);
  localparam int GAIN_W = SHIFT + 1;
  localparam int PROD_W = width_p + GAIN_W + 1;
  localparam int CNT_W  = (clk_div_p > 1) ? $clog2(clk_div_p) : 1;
  localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(fade_steps_p);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(clk_div_p - 1);

  logic [CNT_W-1:0]         tick_cnt;
  logic                     tick;
  logic                     load;
  logic [NUM_WAVES-1:0]     sel_q;
  logic                     sel_valid;
  wave_state_e              state_q, state_d;
  logic [GAIN_W-1:0]        gain_q, gain_d;
  logic [NUM_WAVES-1:0]     active_q, active_d;
  logic signed [width_p-1:0] wave_sel;
  logic signed [PROD_W-1:0] wave_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] product;
  logic signed [width_p-1:0] scaled;

  assign tick = (tick_cnt == CNT_MAX);

  // Free-running sample-rate divider
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Sample load happens the cycle after a tick, once gain/state have settled
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      load <= 1'b0;
    end else begin
      load <= tick;
    end
  end

  switch_debounce #(
    .debounce_p (debounce_p),
    .width_p    (NUM_WAVES)
  ) u_debounce (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_i  (tick),
    .sw_i    (sw_i),
    .sel_o   (sel_q)
  );

  // Zero or several switches on means no waveform is requested
  assign sel_valid = $onehot(sel_q);

  // Fader state, gain and latched waveform
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= MUTE;
      gain_q   <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      active_q <= active_d;
    end
  end

  // Fader transitions; everything moves only on a sample tick
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    active_d = active_q;
    if (tick) begin
      case (state_q)
        MUTE: begin
          gain_d = '0;
          if (sel_valid) begin
            active_d = sel_q;
            state_d  = FADE_IN;
          end
        end
        FADE_IN: begin
          if (sel_q != active_q) begin
            state_d = FADE_OUT;
          end else begin
            gain_d = gain_q + 1'b1;
            if (gain_q == GAIN_MAX - 1'b1) state_d = PLAY;
          end
        end
        PLAY: begin
          gain_d = GAIN_MAX;
          if (sel_q != active_q) state_d = FADE_OUT;
        end
        FADE_OUT: begin
          if (gain_q <= GAIN_W'(1)) begin
            gain_d = '0;
            if (sel_valid) begin
              active_d = sel_q;
              state_d  = FADE_IN;
            end else begin
              active_d = '0;
              state_d  = MUTE;
            end
          end else begin
            gain_d = gain_q - 1'b1;
          end
        end
        default: begin
          state_d  = MUTE;
          gain_d   = '0;
          active_d = '0;
        end
      endcase
    end
  end

  // Advance strobe goes only to the oscillator currently being heard
  assign osc_ready_o = (tick && (state_q != MUTE)) ? active_q : '0;

  // Gain is unsigned, so it is zero-extended before the signed multiply
  assign wave_sel = wave_i[onehot_index(active_q)];
  assign wave_ext = {{(PROD_W - width_p){wave_sel[width_p-1]}}, wave_sel};
  assign gain_ext = {{(PROD_W - GAIN_W){1'b0}}, gain_q};
  assign product  = wave_ext * gain_ext;
  assign scaled   = width_p'(product >>> SHIFT);

  // Output holding register with sticky overrun on an unconsumed overwrite
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (load) begin
      data_o  <= (state_q == MUTE) ? '0 : scaled;
      valid_o <= 1'b1;
      if (valid_o && !ready_i) overrun_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wave_switch_ctrl.sv
// Directed bench for wave_switch_ctrl with a short tick period.
module tb_wave_switch_ctrl;

  localparam int WIDTH    = 24;
  localparam int CLK_DIV  = 8;
  localparam int DEBOUNCE = 4;
  localparam int FADE     = 64;

  logic                         clk_i = 1'b0;
  logic                         reset_i;
  logic [4:0]                   sw_i;
  logic signed [4:0][WIDTH-1:0] wave_i;
  logic [4:0]                   osc_ready_o;
  logic signed [WIDTH-1:0]      data_o;
  logic                         valid_o;
  logic                         ready_i;
  logic                         overrun_o;

  int vectors_applied = 0;
  int miscompares     = 0;
  logic [4:0] strobe;
  int g, es, ed;

  always #5 clk_i = ~clk_i;

  wave_switch_ctrl #(
    .width_p      (WIDTH),
    .clk_div_p    (CLK_DIV),
    .debounce_p   (DEBOUNCE),
    .fade_steps_p (FADE)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .sw_i        (sw_i),
    .wave_i      (wave_i),
    .osc_ready_o (osc_ready_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .overrun_o   (overrun_o)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] sw, input logic rdy);
    sw_i    = sw;
    ready_i = rdy;
  endtask

  // From the negedge just after a load, sample the strobe in the tick cycle
  // and return at the negedge just after the following load
  task automatic step_tick(output logic [4:0] strobe_seen);
    repeat (CLK_DIV - 2) @(negedge clk_i);
    strobe_seen = osc_ready_o;
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    reset_i   = 1'b1;
    wave_i[0] = 24'sh400000;
    wave_i[1] = 24'sh100000;
    wave_i[2] = 24'sh123456;
    wave_i[3] = -24'sd5;
    wave_i[4] = 24'sh7fffff;
    applyStimulus(5'b00000, 1'b1);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_data", data_o, 0);
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_osc", osc_ready_o, 0);
    checkOutput("rst_overrun", overrun_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_noload", valid_o, 0);

    // Sine selected: 4 ticks to debounce, MUTE->FADE_IN, then ramp to PLAY
    applyStimulus(5'b00001, 1'b1);
    for (int n = 1; n <= 70; n++) begin
      step_tick(strobe);
      if (n <= 5) begin
        es = 0; ed = 0;
      end else begin
        g  = (n - 5 > FADE) ? FADE : n - 5;
        es = 1; ed = g * 65536;
      end
      checkOutput($sformatf("fadein_osc@%0d", n), strobe, es);
      checkOutput($sformatf("fadein_data@%0d", n), data_o, ed);
      checkOutput($sformatf("fadein_valid@%0d", n), valid_o, 1);
    end

    // Switch to square: sine fades 64->0, then square fades up to PLAY
    applyStimulus(5'b00010, 1'b1);
    for (int n = 71; n <= 205; n++) begin
      step_tick(strobe);
      if (n <= 75) begin
        es = 1; ed = FADE * 65536;
      end else if (n <= 139) begin
        es = 1; ed = (139 - n) * 65536;
      end else begin
        g  = (n - 139 > FADE) ? FADE : n - 139;
        es = 2; ed = g * 16384;
      end
      checkOutput($sformatf("xfade_osc@%0d", n), strobe, es);
      checkOutput($sformatf("xfade_data@%0d", n), data_o, ed);
    end

    // Three-tick glitch to triangle must not disturb playback
    for (int n = 206; n <= 215; n++) begin
      applyStimulus((n <= 208) ? 5'b00100 : 5'b00010, 1'b1);
      step_tick(strobe);
      checkOutput($sformatf("glitch_osc@%0d", n), strobe, 2);
      checkOutput($sformatf("glitch_data@%0d", n), data_o, 24'sh100000);
    end

    // Handshake: consumption, hold, simultaneous accept+load, overrun
    @(negedge clk_i);
    checkOutput("valid_consumed", valid_o, 0);
    repeat (7) @(negedge clk_i);
    applyStimulus(5'b00010, 1'b0);
    repeat (7) @(negedge clk_i);
    checkOutput("valid_held", valid_o, 1);
    checkOutput("data_held", data_o, 24'sh100000);
    applyStimulus(5'b00010, 1'b1);
    @(negedge clk_i);
    checkOutput("simul_valid", valid_o, 1);
    checkOutput("simul_no_overrun", overrun_o, 0);
    applyStimulus(5'b00010, 1'b0);
    wave_i[1] = 24'sh080000;
    step_tick(strobe);
    checkOutput("overrun_set", overrun_o, 1);
    checkOutput("overrun_data", data_o, 24'sh080000);
    checkOutput("overrun_valid", valid_o, 1);
    step_tick(strobe);
    applyStimulus(5'b00010, 1'b1);
    @(negedge clk_i);
    checkOutput("drain_valid", valid_o, 0);
    repeat (7) @(negedge clk_i);

    // Multi-hot selection with a negative sample: fade out to MUTE
    wave_i[1] = -24'sd64;
    applyStimulus(5'b00011, 1'b1);
    for (int n = 220; n <= 292; n++) begin
      step_tick(strobe);
      if (n <= 224) begin
        es = 2; ed = -64;
      end else if (n <= 288) begin
        es = 2; ed = -(288 - n);
      end else begin
        es = 0; ed = 0;
      end
      checkOutput($sformatf("mute_osc@%0d", n), strobe, es);
      checkOutput($sformatf("mute_data@%0d", n), data_o, ed);
      if (n == 256) checkOutput("neg_gain32", data_o, -32);
    end
    checkOutput("overrun_sticky", overrun_o, 1);

    // Sine again up to gain 20, then reset in a tick cycle
    applyStimulus(5'b00001, 1'b1);
    for (int n = 293; n <= 317; n++) begin
      step_tick(strobe);
      es = (n <= 297) ? 0 : 1;
      ed = (n <= 297) ? 0 : (n - 297) * 65536;
      checkOutput($sformatf("refade_osc@%0d", n), strobe, es);
      checkOutput($sformatf("refade_data@%0d", n), data_o, ed);
    end
    repeat (CLK_DIV - 2) @(negedge clk_i);
    checkOutput("pre_reset_osc", osc_ready_o, 1);
    reset_i = 1'b1;
    @(negedge clk_i);
    checkOutput("midreset_data", data_o, 0);
    checkOutput("midreset_valid", valid_o, 0);
    checkOutput("midreset_osc", osc_ready_o, 0);
    checkOutput("midreset_overrun", overrun_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("postreset_valid", valid_o, 0);
    checkOutput("postreset_data", data_o, 0);
    step_tick(strobe);
    checkOutput("postreset_osc", strobe, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
